// File: rtl/uart_tx_ctrl_if.sv
// rtl/uart_tx_ctrl_if.sv - data/serializer/line signal bundle for uart_tx_ctrl
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  ser_done;
    logic                  ser_data;
    logic                  ser_en;
    logic                  busy;
    logic                  TX_OUT;
    logic                  frame_err;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
        input  ser_en, busy, TX_OUT, frame_err
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
        output ser_en, busy, TX_OUT, frame_err
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART TX frame controller: start/data/parity/stop sequencing with serializer handshake
// Optional two-cycle stop bit enabled by defining UART_TX_TWO_STOP_EN.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int DONE_TIMEOUT = 12
) (
    input  logic           Clk,
    input  logic           RST,
    uart_tx_ctrl_if.slave  bus
);
    localparam int CW = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          parity_reg;
    logic          par_en_reg;
    logic [CW-1:0] tmo_cnt;
    logic          frame_err_reg;
    logic          timeout;
    logic          stop_done;

    assign timeout = (state == DATA) && !bus.ser_done && (tmo_cnt == CW'(DONE_TIMEOUT - 1));

`ifdef UART_TX_TWO_STOP_EN
    logic stop_cnt;

    // Zero on STOP entry, so the second STOP cycle is the one with stop_cnt set.
    always_ff @(posedge Clk or negedge RST) begin
        if (!RST)
            stop_cnt <= 1'b0;
        else if (state == STOP)
            stop_cnt <= 1'b1;
        else
            stop_cnt <= 1'b0;
    end

    assign stop_done = stop_cnt;
`else
    assign stop_done = 1'b1;
`endif

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            parity_reg    <= 1'b0;
            par_en_reg    <= 1'b0;
            tmo_cnt       <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= timeout;
            if (state == IDLE && bus.Data_Valid) begin
                parity_reg <= (^bus.P_DATA) ^ bus.PAR_TYP;
                par_en_reg <= bus.PAR_EN;
            end
            if (state == START)
                tmo_cnt <= '0;
            else if (state == DATA)
                tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (bus.Data_Valid) state_nxt = START;
            START:  state_nxt = DATA;
            DATA: begin
                if (bus.ser_done)
                    state_nxt = par_en_reg ? PARITY : STOP;
                else if (timeout)
                    state_nxt = IDLE;
            end
            PARITY: state_nxt = STOP;
            STOP:   if (stop_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ser_en = 1'b0;
        bus.busy   = 1'b0;
        bus.TX_OUT = 1'b1;
        case (state)
            START: begin
                bus.ser_en = 1'b1;
                bus.busy   = 1'b1;
                bus.TX_OUT = 1'b0;
            end
            DATA: begin
                bus.ser_en = ~bus.ser_done;
                bus.busy   = 1'b1;
                bus.TX_OUT = bus.ser_data;
            end
            PARITY: begin
                bus.busy   = 1'b1;
                bus.TX_OUT = parity_reg;
            end
            STOP: begin
                bus.busy   = 1'b1;
            end
            default: begin
                bus.ser_en = 1'b0;
            end
        endcase
    end

    assign bus.frame_err = frame_err_reg;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - randomized, model-checked bench for uart_tx_ctrl
module tb_uart_tx_ctrl;
`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic Clk;
    logic RST;
    logic stuck;
    int   total = 0;
    int   bad   = 0;

    uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_ctrl #(.DATA_WIDTH(8), .DONE_TIMEOUT(12)) dut (
        .Clk (Clk),
        .RST (RST),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Serializer: reloads while busy=0, presents one bit per ser_en; stuck suppresses ser_done.
    logic [7:0] s_reg;
    logic [3:0] s_cnt;
    always @(posedge Clk or negedge RST) begin
        if (!RST) begin
            s_reg        <= 8'h00;
            s_cnt        <= 4'd0;
            bus.ser_data <= 1'b0;
            bus.ser_done <= 1'b0;
        end else if (!bus.busy) begin
            s_reg        <= bus.P_DATA;
            s_cnt        <= 4'd0;
            bus.ser_done <= 1'b0;
        end else if (bus.ser_en) begin
            bus.ser_data <= s_reg[s_cnt[2:0]];
            bus.ser_done <= !stuck && (s_cnt == 4'd7);
            s_cnt        <= s_cnt + 4'd1;
        end
    end

    // Reference: a frame is a precomputed list of line levels indexed by cycle position.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic pe, input logic pt, input logic st);
        logic [15:0] b;
        b    = '1;
        b[0] = 1'b0;
        if (st) begin
            for (int i = 0; i < 12; i++) b[1+i] = d[i%8];
        end else begin
            for (int i = 0; i < 8; i++) b[1+i] = d[i];
            if (pe) b[9] = (^d) ^ pt;
        end
        return b;
    endfunction

    function automatic int frame_len(input logic pe, input logic st);
        return st ? 13 : (9 + int'(pe) + NSTOP);
    endfunction

    function automatic logic [15:0] frame_sen(input logic st);
        return st ? 16'h1FFF : 16'h00FF;
    endfunction

    logic        m_active, m_to, m_err;
    int          m_pos, m_len;
    logic [15:0] m_tx, m_sen;

    always @(posedge Clk or negedge RST) begin
        if (!RST) begin
            m_active <= 1'b0;
            m_to     <= 1'b0;
            m_err    <= 1'b0;
            m_pos    <= 0;
            m_len    <= 0;
            m_tx     <= '1;
            m_sen    <= '0;
        end else if (m_active) begin
            m_err <= 1'b0;
            if (m_pos + 1 == m_len) begin
                m_active <= 1'b0;
                m_err    <= m_to;
            end
            m_pos <= m_pos + 1;
        end else begin
            m_err <= 1'b0;
            if (bus.Data_Valid) begin
                m_active <= 1'b1;
                m_pos    <= 0;
                m_to     <= stuck;
                m_len    <= frame_len(bus.PAR_EN, stuck);
                m_tx     <= frame_bits(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP, stuck);
                m_sen    <= frame_sen(stuck);
            end
        end
    end

    always @(negedge Clk) begin
        check("tx_out", int'(bus.TX_OUT), m_active ? int'(m_tx[m_pos[3:0]]) : 1);
        check("busy", int'(bus.busy), int'(m_active));
        check("ser_en", int'(bus.ser_en), m_active ? int'(m_sen[m_pos[3:0]]) : 0);
        check("frame_err", int'(bus.frame_err), int'(m_err));
    end

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic send_capture(input logic [7:0] d, input logic pe, input logic pt, input logic chg,
                                output logic [15:0] seq, output int bcnt, output int ecnt);
        seq  = '0;
        bcnt = 0;
        ecnt = 0;
        step();
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Data_Valid = 1'b1;
        step();
        bus.Data_Valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            seq[k] = bus.TX_OUT;
            bcnt  += int'(bus.busy);
            ecnt  += int'(bus.frame_err);
            if (chg && k == 3) begin
                bus.P_DATA  = 8'hFF;
                bus.PAR_TYP = ~pt;
                bus.PAR_EN  = ~pe;
            end
            step();
        end
    endtask

    logic [15:0] seq;
    int          bc, ec, g;
    logic [7:0]  b2;

    initial begin
        RST            = 1'b0;
        stuck          = 1'b0;
        bus.P_DATA     = 8'h00;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        repeat (3) step();
        RST = 1'b1;
        step();
        check("rst_tx", int'(bus.TX_OUT), 1);
        check("rst_busy", int'(bus.busy), 0);

        send_capture(8'hA5, 1'b0, 1'b0, 1'b0, seq, bc, ec);
        check("a5_noparity_seq", int'(seq[9:0]), int'(10'b1101001010));
        check("a5_noparity_busy", bc, 9 + NSTOP);

        send_capture(8'h01, 1'b1, 1'b0, 1'b0, seq, bc, ec);
        check("even_seq", int'(seq[10:0]), int'(11'b11000000010));
        check("even_busy", bc, 10 + NSTOP);

        send_capture(8'hA5, 1'b1, 1'b1, 1'b1, seq, bc, ec);
        check("odd_data", int'(seq[8:0]), int'(9'b101001010));
        check("odd_parity", int'(seq[9]), 1);
        check("odd_busy", bc, 10 + NSTOP);

        step();
        bus.P_DATA     = 8'h55;
        bus.PAR_EN     = 1'b0;
        bus.Data_Valid = 1'b1;
        step();
        bus.P_DATA = 8'h0F;
        g = 0;
        while (bus.busy && g < 20) begin g++; step(); end
        check("b2b_frame1_len", g, 9 + NSTOP);
        g = 0;
        while (!bus.busy && g < 10) begin g++; step(); end
        check("b2b_gap", g, 1);
        bus.Data_Valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            b2[i] = bus.TX_OUT;
        end
        check("b2b_frame2_data", int'(b2), 8'h0F);
        repeat (6) step();

        stuck = 1'b1;
        send_capture(8'h3C, 1'b1, 1'b0, 1'b0, seq, bc, ec);
        check("timeout_busy", bc, 13);
        check("timeout_err_pulses", ec, 1);
        check("timeout_idle_line", int'(seq[15:13]), 7);
        stuck = 1'b0;
        send_capture(8'h81, 1'b1, 1'b0, 1'b0, seq, bc, ec);
        check("post_timeout_data", int'(seq[8:0]), int'(9'b100000010));
        check("post_timeout_parity", int'(seq[9]), 0);
        check("post_timeout_err", ec, 0);

        step();
        bus.P_DATA     = 8'hC3;
        bus.Data_Valid = 1'b1;
        step();
        bus.Data_Valid = 1'b0;
        repeat (3) step();
        RST = 1'b0;
        #1;
        check("midrst_tx", int'(bus.TX_OUT), 1);
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_ser_en", int'(bus.ser_en), 0);
        check("midrst_err", int'(bus.frame_err), 0);
        repeat (3) step();
        RST = 1'b1;
        send_capture(8'hA5, 1'b0, 1'b0, 1'b0, seq, bc, ec);
        check("after_rst_seq", int'(seq[9:0]), int'(10'b1101001010));

        for (int ph = 0; ph < 2; ph++) begin
            stuck = (ph == 1);
            repeat (ph == 0 ? 400 : 120) begin
                step();
                bus.P_DATA     = 8'($urandom);
                bus.PAR_EN     = 1'($urandom);
                bus.PAR_TYP    = 1'($urandom);
                bus.Data_Valid = ($urandom_range(0, 2) != 0);
            end
            bus.Data_Valid = 1'b0;
            repeat (20) step();
        end
        stuck = 1'b0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
